// File: rtl/modn_tick_gen.sv
// Programmable modulo-N counter with wrap tick, one-shot/continuous and up/down modes,
// plus a saturating count of ticks since the last start. Common timebase for downstream logic.
module modn_tick_gen #(
    parameter int WIDTH        = 3,
    parameter int DEFAULT_TERM = (1 << WIDTH) - 1,
    parameter bit AUTO_START   = 1'b1,
    parameter int TC_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             dir,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic [TC_W-1:0]  tick_cnt
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic             tick_q,    tick_d;
    logic [TC_W-1:0]  tc_q,      tc_d;
    logic [WIDTH-1:0] term_q,    term_d;
    logic             dir_q,     dir_d;
    logic             oneshot_q, oneshot_d;
    logic             at_term;

    function automatic logic [TC_W-1:0] sat_inc(input logic [TC_W-1:0] v);
        return (&v) ? v : v + TC_W'(1);
    endfunction

    // Terminal depends on the direction latched for the current period.
    assign at_term = dir_q ? (count_q == '0) : (count_q == term_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        tc_d      = tc_q;
        term_d    = term_q;
        dir_d     = dir_q;
        oneshot_d = oneshot_q;
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            term_d    = term;
            dir_d     = dir;
            oneshot_d = oneshot;
            count_d   = dir ? term : '0;
            tc_d      = '0;
            state_d   = RUN;
        end else if (state_q == RUN && en) begin
            if (at_term) begin
                tick_d  = 1'b1;
                tc_d    = sat_inc(tc_q);
                term_d  = term;
                dir_d   = dir;
                count_d = dir ? term : '0;
                if (oneshot_q) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end else begin
                count_d = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= AUTO_START ? RUN : IDLE;
            count_q   <= '0;
            tick_q    <= 1'b0;
            tc_q      <= '0;
            term_q    <= WIDTH'(DEFAULT_TERM);
            dir_q     <= 1'b0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            term_q    <= term_d;
            dir_q     <= dir_d;
            oneshot_q <= oneshot_d;
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign busy     = (state_q == RUN);
    assign tick_cnt = tc_q;

endmodule

// File: tb/tb_modn_tick_gen.sv
// Scoreboard bench for modn_tick_gen: two instances (TC_W=8 and TC_W=2) share one stimulus stream;
// expected values are queued per edge and popped by an independent monitor.
module tb_modn_tick_gen;

    logic       clk = 1'b0;
    logic       reset, en, start, stop, oneshot, dir;
    logic [2:0] term;
    logic [2:0] count, count2;
    logic       tick, tick2, busy, busy2;
    logic [7:0] tick_cnt;
    logic [1:0] tick_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c;
        int t;
        int b;
        int tc;
        int tc2;
    } exp_t;

    exp_t sb[$];

    modn_tick_gen #(.WIDTH(3), .AUTO_START(1'b1), .TC_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .oneshot(oneshot), .dir(dir), .term(term),
        .count(count), .tick(tick), .busy(busy), .tick_cnt(tick_cnt)
    );

    modn_tick_gen #(.WIDTH(3), .AUTO_START(1'b1), .TC_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .oneshot(oneshot), .dir(dir), .term(term),
        .count(count2), .tick(tick2), .busy(busy2), .tick_cnt(tick_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".count"},     int'(count),     e.c);
        chk({tag, ".tick"},      int'(tick),      e.t);
        chk({tag, ".busy"},      int'(busy),      e.b);
        chk({tag, ".tick_cnt"},  int'(tick_cnt),  e.tc);
        chk({tag, ".count2"},    int'(count2),    e.c);
        chk({tag, ".tick2"},     int'(tick2),     e.t);
        chk({tag, ".tick_cnt2"}, int'(tick_cnt2), e.tc2);
    endtask

    function automatic exp_t mk(input int c, input int t, input int b, input int tc);
        exp_t e;
        e.c   = c;
        e.t   = t;
        e.b   = b;
        e.tc  = tc;
        e.tc2 = (tc > 3) ? 3 : tc;
        return e;
    endfunction

    // Drive one edge worth of inputs and queue the state expected right after that edge.
    task automatic step(input bit e, input bit s, input bit p, input bit o, input bit d,
                        input int t, input int ec, input int et, input int eb, input int etc);
        @(negedge clk);
        en      = e;
        start   = s;
        stop    = p;
        oneshot = o;
        dir     = d;
        term    = 3'(t);
        sb.push_back(mk(ec, et, eb, etc));
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk_all("edge", e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
        oneshot = 1'b0; dir = 1'b0; term = 3'd7;
        #12;
        chk_all("reset", mk(0, 0, 1, 0));
        @(negedge clk);
        reset = 1'b0;

        // Out of reset, en low: RUN holds
        step(0, 0, 0, 0, 0, 7, 0, 0, 1, 0);

        // Default modulus 8 with no start
        for (int k = 1; k <= 24; k++)
            step(1, 0, 0, 0, 0, 7, k % 8, (k % 8 == 0) ? 1 : 0, 1, k / 8);

        // term=4 up continuous, en alternating
        step(0, 1, 0, 0, 0, 4, 0, 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 0, 0, 0, 4, k % 5, (k % 5 == 0) ? 1 : 0, 1, k / 5);
            step(0, 0, 0, 0, 0, 4, k % 5, 0, 1, k / 5);
        end

        // term=3 down one-shot
        step(1, 1, 0, 1, 1, 3, 3, 0, 1, 0);
        step(1, 0, 0, 1, 1, 3, 2, 0, 1, 0);
        step(1, 0, 0, 1, 1, 3, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 3, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 3, 0, 1, 0, 1);
        step(1, 0, 0, 1, 1, 3, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 3, 0, 0, 0, 1);

        // term=6, switched to 2 mid-period
        step(1, 1, 0, 0, 0, 6, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 6, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 6, 2, 0, 1, 0);
        step(1, 0, 0, 0, 0, 6, 3, 0, 1, 0);
        step(1, 0, 0, 0, 0, 2, 4, 0, 1, 0);
        step(1, 0, 0, 0, 0, 2, 5, 0, 1, 0);
        step(1, 0, 0, 0, 0, 2, 6, 0, 1, 0);
        step(1, 0, 0, 0, 0, 2, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 2, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 2, 2, 0, 1, 1);
        step(1, 0, 0, 0, 0, 2, 0, 1, 1, 2);
        step(1, 0, 0, 0, 0, 2, 1, 0, 1, 2);
        step(1, 0, 0, 0, 0, 2, 2, 0, 1, 2);
        step(1, 0, 0, 0, 0, 2, 0, 1, 1, 3);
        step(1, 0, 0, 0, 0, 2, 1, 0, 1, 3);
        // stop wins over start; tick_cnt holds
        step(1, 1, 1, 0, 0, 2, 0, 0, 0, 3);
        step(1, 0, 0, 0, 0, 2, 0, 0, 0, 3);
        step(1, 0, 0, 0, 0, 2, 0, 0, 0, 3);

        // term=2 down continuous, reload lands on term
        step(1, 1, 0, 0, 1, 2, 2, 0, 1, 0);
        for (int k = 1; k <= 6; k++)
            step(1, 0, 0, 0, 1, 2, (k % 3 == 0) ? 2 : 2 - (k % 3),
                 (k % 3 == 0) ? 1 : 0, 1, k / 3);

        // term=0: tick every edge, 2-bit tick_cnt saturates
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 5; k++)
            step(1, 0, 0, 0, 0, 0, 0, 1, 1, k);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        // Async reset mid-count at count=5 with tick_cnt=1
        step(1, 1, 0, 0, 0, 7, 0, 0, 1, 0);
        for (int k = 1; k <= 13; k++)
            step(1, 0, 0, 0, 0, 7, k % 8, (k % 8 == 0) ? 1 : 0, 1, k / 8);
        #3;
        reset = 1'b1;
        en    = 1'b0;
        #1;
        chk_all("async_reset", mk(0, 0, 1, 0));
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 7, 2, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
